// File: rtl/mem_access_if.sv
// Pipeline-request and data-memory bus bundle for the MEM-stage access master.
// master: the access controller; slave: the pipeline/memory side that drives it.
interface mem_access_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        freeze;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
      output req_ready, freeze, done, err, rdata, mem_r_en, mem_w_en, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, mem_rdata,
      input  req_ready, freeze, done, err, rdata, mem_r_en, mem_w_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_master.sv
// MEM-stage data-memory access controller: one load/store at a time, WAIT_CYCLES wait states.
// Define MEM_ALIGN_CHECK_EN to reject misaligned or out-of-range requests with err.
module mem_access_master #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned DEPTH_WORDS = 2048
) (
   input  logic         clk,
   input  logic         rst,
   mem_access_if.master bus_io
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

   if (WAIT_CYCLES > 15 || DEPTH_WORDS == 0 || BASE_ADDR[1:0] != 2'b00) begin : g_bad_param
      $error("mem_access_master: illegal parameter combination");
   end

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        done_q;
   logic        err_q;
   logic        r_en_q;
   logic        w_en_q;
   logic        reject;
   logic        w_en;
   logic        en_any;

`ifdef MEM_ALIGN_CHECK_EN
   localparam logic [32:0] AddrLo = 33'(BASE_ADDR);
   localparam logic [32:0] AddrHi = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

   assign reject = (bus_io.req_addr[1:0] != 2'b00) ||
                   ({1'b0, bus_io.req_addr} < AddrLo) ||
                   ({1'b0, bus_io.req_addr} >= AddrHi);
`else
   assign reject = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         r_en_q  <= 1'b0;
         w_en_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus_io.req_valid) begin
                  write_q <= bus_io.req_write;
                  addr_q  <= bus_io.req_addr;
                  wdata_q <= bus_io.req_wdata;
                  cnt_q   <= WaitInit;
                  if (reject) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= StAccess;
                     r_en_q  <= ~bus_io.req_write;
                     // Store strobe only lands on the last ACCESS cycle.
                     w_en_q  <= bus_io.req_write && (WaitInit == 4'd0);
                  end
               end
            end
            StAccess: begin
               if (cnt_q != 4'd0) begin
                  cnt_q  <= cnt_q - 4'd1;
                  w_en_q <= write_q && (cnt_q == 4'd1);
               end else begin
                  if (!write_q) rdata_q <= bus_io.mem_rdata;
                  r_en_q  <= 1'b0;
                  w_en_q  <= 1'b0;
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // A reset coinciding with the final store edge must not let the write escape.
   assign w_en   = w_en_q & ~rst;
   assign en_any = r_en_q | w_en;

   assign bus_io.req_ready = (state_q == StIdle);
   assign bus_io.freeze    = ((state_q == StIdle) && bus_io.req_valid) || (state_q == StAccess);
   assign bus_io.done      = done_q;
   assign bus_io.err       = err_q;
   assign bus_io.rdata     = rdata_q;
   assign bus_io.mem_r_en  = r_en_q;
   assign bus_io.mem_w_en  = w_en;
   assign bus_io.mem_addr  = en_any ? addr_q : 32'd0;
   assign bus_io.mem_wdata = en_any ? wdata_q : 32'd0;

endmodule
